// File: rtl/ecc_scrub_pkg.sv
// Shared types and widths for the background ECC scrubber.
package ecc_scrub_pkg;

    localparam int ECC_WORD_W = 39;
    localparam int DATA_W     = 32;
    localparam int ECC_W      = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_CHECK   = 3'd4,
        ST_WR_REQ  = 3'd5,
        ST_NEXT    = 3'd6
    } scrub_state_e;

endpackage

// File: rtl/rvecc_decode.sv
// SECDED (39,32) decoder: Hamming code over positions 1..38 plus an overall parity bit ecc[6].
module rvecc_decode (
    input  logic        en,
    input  logic [31:0] din,
    input  logic [6:0]  ecc_in,
    input  logic        sed_ded,
    output logic [31:0] dout,
    output logic [6:0]  ecc_out,
    output logic        single_ecc_error,
    output logic        double_ecc_error
);

    logic [38:1] cw;
    logic [38:1] fixed;
    logic [5:0]  syn;
    logic        par;
    logic        do_fix;

    // Check bits sit at the power-of-two codeword positions.
    assign cw = {din[31:26], ecc_in[5], din[25:11], ecc_in[4], din[10:4], ecc_in[3],
                 din[3:1], ecc_in[2], din[0], ecc_in[1], ecc_in[0]};
    assign par = ^{din, ecc_in};

    always_comb begin
        syn = '0;
        for (int p = 1; p <= 38; p++) begin
            if (cw[p]) syn = syn ^ 6'(p);
        end
    end

    assign single_ecc_error = en & par;
    assign double_ecc_error = en & ~par & (syn != 6'd0);
    assign do_fix           = single_ecc_error & ~sed_ded;

    always_comb begin
        fixed = cw;
        for (int p = 1; p <= 38; p++) begin
            fixed[p] = cw[p] ^ (do_fix && (syn == 6'(p)));
        end
    end

    assign dout    = {fixed[38:33], fixed[31:17], fixed[15:9], fixed[7:5], fixed[3]};
    assign ecc_out = {ecc_in[6] ^ (do_fix && (syn == 6'd0)),
                      fixed[32], fixed[16], fixed[8], fixed[4], fixed[2], fixed[1]};

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: reads each word, writes back single-error fixes, logs double errors.
// Optional fault injection on the captured read word when ECC_SCRUB_INJECT_EN is defined.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int INTERVAL_W = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  scrub_en,
    input  logic [INTERVAL_W-1:0] scrub_interval,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [ECC_WORD_W-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [ECC_WORD_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]      sec_count,
    output logic [CNT_W-1:0]      ded_count,
    output logic [ADDR_W-1:0]     last_ded_addr,
    output logic                  ded_irq,
    input  logic                  ded_irq_clr,
`ifdef ECC_SCRUB_INJECT_EN
    input  logic                  inj_arm,
    input  logic [5:0]            inj_pos,
`endif
    output logic                  pass_done,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    scrub_state_e          state;
    logic [ADDR_W-1:0]     addr;
    logic [INTERVAL_W-1:0] wait_cnt;
    logic [ECC_WORD_W-1:0] rd_word;
    logic [ECC_WORD_W-1:0] inj_mask;
    logic [DATA_W-1:0]     dec_dout;
    logic [ECC_W-1:0]      dec_ecc;
    logic                  dec_sec;
    logic                  dec_ded;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rvecc_decode u_dec (
        .en               (state == ST_CHECK),
        .din              (rd_word[DATA_W-1:0]),
        .ecc_in           (rd_word[ECC_WORD_W-1:DATA_W]),
        .sed_ded          (1'b0),
        .dout             (dec_dout),
        .ecc_out          (dec_ecc),
        .single_ecc_error (dec_sec),
        .double_ecc_error (dec_ded)
    );

    // Request lines decode straight from state so an async reset drops them at once.
    assign mem_req  = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign mem_we   = (state == ST_WR_REQ);
    assign mem_addr = addr;
    assign busy     = (state != ST_IDLE);

`ifdef ECC_SCRUB_INJECT_EN
    logic inj_armed;

    always_comb begin
        inj_mask = '0;
        for (int i = 0; i < ECC_WORD_W; i++) begin
            inj_mask[i] = inj_armed && (inj_pos == 6'(i));
        end
    end

    // One-shot is consumed by the next captured word, even when inj_pos is out of range.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inj_armed <= 1'b0;
        end else if (state == ST_RD_RESP && mem_rvalid && inj_armed) begin
            inj_armed <= 1'b0;
        end else if (inj_arm) begin
            inj_armed <= 1'b1;
        end
    end
`else
    assign inj_mask = '0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= ST_IDLE;
            addr          <= '0;
            wait_cnt      <= '0;
            rd_word       <= '0;
            mem_wdata     <= '0;
            sec_count     <= '0;
            ded_count     <= '0;
            last_ded_addr <= '0;
            ded_irq       <= 1'b0;
            pass_done     <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            if (ded_irq_clr) ded_irq <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scrub_en) begin
                        state    <= ST_WAIT;
                        wait_cnt <= scrub_interval;
                    end
                end
                ST_WAIT: begin
                    if (!scrub_en) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= ST_RD_REQ;
                    end else begin
                        wait_cnt <= wait_cnt - INTERVAL_W'(1);
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt) state <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (mem_rvalid) begin
                        rd_word <= mem_rdata ^ inj_mask;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (dec_sec) begin
                        sec_count <= sat_inc(sec_count);
                        mem_wdata <= {dec_ecc, dec_dout};
                        state     <= ST_WR_REQ;
                    end else if (dec_ded) begin
                        ded_count     <= sat_inc(ded_count);
                        last_ded_addr <= addr;
                        ded_irq       <= 1'b1;
                        state         <= ST_NEXT;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (addr == LAST_ADDR) begin
                        addr      <= '0;
                        pass_done <= 1'b1;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                    if (scrub_en) begin
                        state    <= ST_WAIT;
                        wait_cnt <= scrub_interval;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl on a 4-word array with a behavioural memory responder.
`timescale 1ns/1ps
module tb_ecc_scrub_ctrl;

    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 2;
    localparam int INTERVAL_W = 16;
    localparam int CNT_W      = 16;

    logic                  clk = 1'b0;
    logic                  rst_l;
    logic                  scrub_en;
    logic [INTERVAL_W-1:0] scrub_interval;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [38:0]           mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [38:0]           mem_rdata;
    logic [CNT_W-1:0]      sec_count;
    logic [CNT_W-1:0]      ded_count;
    logic [ADDR_W-1:0]     last_ded_addr;
    logic                  ded_irq;
    logic                  ded_irq_clr;
    logic                  pass_done;
    logic                  busy;
`ifdef ECC_SCRUB_INJECT_EN
    logic                  inj_arm;
    logic [5:0]            inj_pos;
`endif

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL_W(INTERVAL_W), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .scrub_en       (scrub_en),
        .scrub_interval (scrub_interval),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .sec_count      (sec_count),
        .ded_count      (ded_count),
        .last_ded_addr  (last_ded_addr),
        .ded_irq        (ded_irq),
        .ded_irq_clr    (ded_irq_clr),
`ifdef ECC_SCRUB_INJECT_EN
        .inj_arm        (inj_arm),
        .inj_pos        (inj_pos),
`endif
        .pass_done      (pass_done),
        .busy           (busy)
    );

    typedef struct {
        int          addr;
        logic [38:0] flip;
        int          wr;
        int          sec;
        int          ded;
        int          last;
        int          irq;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_reads, n_writes, n_pass, cyc;
    logic [38:0] mem    [DEPTH];
    logic [38:0] golden [DEPTH];
    logic [40:0] exp_q  [$];
    logic [40:0] exp_wr;
    bit          rd_pending;
    logic [38:0] rd_data;

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [6:0] e;
        e[0] = ^(d & 32'h56AAAD5B);
        e[1] = ^(d & 32'h9B33366D);
        e[2] = ^(d & 32'hE3C3C78E);
        e[3] = ^(d & 32'h03FC07F0);
        e[4] = ^(d & 32'h03FFF800);
        e[5] = ^(d & 32'hFC000000);
        e[6] = ^{d, e[5:0]};
        return {e, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;
    initial forever begin
        @(negedge clk);
        if (pass_done === 1'b1) n_pass++;
    end

    // Memory responder: read data returns one cycle after the grant cycle.
    initial forever begin
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (rd_pending) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_data;
            rd_pending = 1'b0;
        end
        if (rst_l && mem_req && mem_gnt) begin
            if (mem_we) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %h, no write required", mem_addr, mem_wdata);
                end else begin
                    exp_wr = exp_q.pop_front();
                    check("wb_addr_data", {mem_addr, mem_wdata}, exp_wr);
                end
                mem[mem_addr] = mem_wdata;
            end else begin
                n_reads++;
                rd_pending = 1'b1;
                rd_data    = mem[mem_addr];
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_l          = 1'b0;
        scrub_en       = 1'b0;
        ded_irq_clr    = 1'b0;
        scrub_interval = '0;
        mem_gnt        = 1'b1;
`ifdef ECC_SCRUB_INJECT_EN
        inj_arm        = 1'b0;
        inj_pos        = '0;
`endif
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rd_pending = 1'b0;
        n_reads    = 0;
        n_writes   = 0;
        n_pass     = 0;
        exp_q.delete();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = golden[i];
    endtask

    task automatic run_pass(output bit ok);
        ok = 1'b0;
        scrub_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pass_done) begin
                ok = 1'b1;
                break;
            end
        end
        scrub_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rd(output logic [ADDR_W-1:0] a, output int t, output bit ok);
        ok = 1'b0;
        a  = '0;
        t  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_gnt) begin
                a  = mem_addr;
                t  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_rd_addr(input logic [ADDR_W-1:0] want, output bit ok);
        logic [ADDR_W-1:0] a;
        int t;
        ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_rd(a, t, ok);
            if (!ok) return;
            if (a == want) return;
        end
        ok = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs [6];
        bit                ok;
        logic [ADDR_W-1:0] a0, a1, ha;
        int                t0, t1;
        logic              hwe;

        rst_l = 1'b0; scrub_en = 1'b0; ded_irq_clr = 1'b0; scrub_interval = '0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; rd_pending = 1'b0;
        n_reads = 0; n_writes = 0; n_pass = 0; cyc = 0;
`ifdef ECC_SCRUB_INJECT_EN
        inj_arm = 1'b0; inj_pos = '0;
`endif
        for (int i = 0; i < DEPTH; i++) golden[i] = encode(32'h1234_5678 ^ (i * 32'h0101_0F0F));

        vecs[0] = '{0, 39'd0,                       0, 0, 0, 0, 0};
        vecs[1] = '{2, 39'd1 << 5,                  1, 1, 0, 0, 0};
        vecs[2] = '{1, (39'd1 << 3) | (39'd1 << 20), 0, 0, 1, 1, 1};
        vecs[3] = '{3, 39'd1 << 38,                 1, 1, 0, 0, 0};
        vecs[4] = '{0, 39'd1 << 32,                 1, 1, 0, 0, 0};
        vecs[5] = '{3, 39'd1 | (39'd1 << 38),       0, 0, 1, 3, 1};

        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_counts", {sec_count, ded_count}, 0);
        check("rst_ded_flags", {last_ded_addr, ded_irq, pass_done}, 0);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            load_mem();
            mem[vecs[k].addr] = mem[vecs[k].addr] ^ vecs[k].flip;
            if (vecs[k].wr != 0) exp_q.push_back({ADDR_W'(vecs[k].addr), golden[vecs[k].addr]});
            run_pass(ok);
            check($sformatf("v%0d_pass_seen", k), ok, 1);
            check($sformatf("v%0d_sec", k), sec_count, vecs[k].sec);
            check($sformatf("v%0d_ded", k), ded_count, vecs[k].ded);
            check($sformatf("v%0d_last_ded", k), last_ded_addr, vecs[k].last);
            check($sformatf("v%0d_irq", k), ded_irq, vecs[k].irq);
            check($sformatf("v%0d_reads", k), n_reads, DEPTH);
            check($sformatf("v%0d_writes", k), n_writes, vecs[k].wr);
            check($sformatf("v%0d_pass_cnt", k), n_pass, 1);
            check($sformatf("v%0d_wb_pending", k), exp_q.size(), 0);
            check($sformatf("v%0d_busy", k), busy, 0);
        end

        // Double errors at 1 and 3: clear after the first, clear coincident with the second.
        do_reset();
        load_mem();
        mem[1] = mem[1] ^ ((39'd1 << 3) | (39'd1 << 20));
        mem[3] = mem[3] ^ ((39'd1 << 3) | (39'd1 << 20));
        scrub_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ded_count == 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("ded1_seen", ok, 1);
        check("ded1_irq_set", ded_irq, 1);
        ded_irq_clr = 1'b1;
        @(negedge clk);
        ded_irq_clr = 1'b0;
        check("ded1_irq_cleared", ded_irq, 0);
        wait_rd_addr(2'd3, ok);
        check("ded2_read_seen", ok, 1);
        @(negedge clk);
        @(negedge clk);
        ded_irq_clr = 1'b1;
        @(negedge clk);
        ded_irq_clr = 1'b0;
        check("ded2_set_wins", ded_irq, 1);
        check("ded2_count", ded_count, 2);
        check("ded2_last_addr", last_ded_addr, 3);
        scrub_en = 1'b0;

        // Interval spacing, then a held-off grant on the third word.
        do_reset();
        load_mem();
        scrub_interval = 16'd10;
        scrub_en = 1'b1;
        wait_rd(a0, t0, ok);
        check("intv_rd0_addr", {ok, a0}, {1'b1, 2'd0});
        wait_rd(a1, t1, ok);
        check("intv_rd1_addr", {ok, a1}, {1'b1, 2'd1});
        n_cmp++;
        if (t1 - t0 < 15) begin
            n_fail++;
            $display("FAIL intv_spacing: got %0d cycles, required >= 15", t1 - t0);
        end
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("hold_req_seen", ok, 1);
        ha  = mem_addr;
        hwe = mem_we;
        check("hold_addr", {ha, hwe}, {2'd2, 1'b0});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("hold_stable_%0d", i), {mem_req, mem_we, mem_addr}, {1'b1, hwe, ha});
        end
        @(posedge clk);
        #1 mem_gnt = 1'b1;
        scrub_en = 1'b0;
        repeat (25) @(negedge clk);
        check("hold_idle_after", busy, 0);

        // Enable dropped during CHECK of a single-error word.
        do_reset();
        load_mem();
        mem[2] = mem[2] ^ (39'd1 << 5);
        exp_q.push_back({2'd2, golden[2]});
        scrub_en = 1'b1;
        wait_rd_addr(2'd2, ok);
        check("drop_read_seen", ok, 1);
        @(negedge clk);
        @(negedge clk);
        scrub_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drop_idle", ok, 1);
        check("drop_writes", n_writes, 1);
        check("drop_wb_pending", exp_q.size(), 0);
        check("drop_sec", sec_count, 1);
        scrub_en = 1'b1;
        wait_rd(a0, t0, ok);
        check("resume_addr", {ok, a0}, {1'b1, 2'd3});
        @(negedge clk);
        check("rdresp_busy", busy, 1);
        rst_l = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_addr_we", {mem_addr, mem_we}, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_counts", {sec_count, ded_count}, 0);
        check("arst_flags", {last_ded_addr, ded_irq, pass_done}, 0);
        scrub_en = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_resp_ignored", {busy, sec_count}, 0);

        // Reset while a read request is waiting on grant.
        do_reset();
        load_mem();
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        scrub_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("rdreq_seen", ok, 1);
        rst_l = 1'b0;
        #1;
        check("rdreq_arst_req", mem_req, 0);

`ifdef ECC_SCRUB_INJECT_EN
        do_reset();
        load_mem();
        inj_pos = 6'd38;
        inj_arm = 1'b1;
        @(negedge clk);
        inj_arm = 1'b0;
        exp_q.push_back({2'd0, golden[0]});
        run_pass(ok);
        check("inj_pass_seen", ok, 1);
        check("inj_sec", sec_count, 1);
        check("inj_writes", n_writes, 1);
        check("inj_wb_pending", exp_q.size(), 0);
        check("inj_mem_clean", mem[0], golden[0]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
